// File: rtl/teclado_cajero_pkg.sv
// Types and helpers shared by the keypad controller; constants come from teclado_cajero_defs.vh.
package teclado_cajero_pkg;
`include "teclado_cajero_defs.vh"

  typedef enum logic [2:0] {
    E_IDLE      = ST_IDLE,
    E_PIN       = ST_PIN,
    E_TIPO      = ST_TIPO,
    E_MONTO     = ST_MONTO,
    E_FIN       = ST_FIN,
    E_BLOQUEADO = ST_BLOQUEADO
  } estado_t;

  function automatic logic es_digito(input logic [3:0] t);
    return t <= 4'd9;
  endfunction
endpackage

// File: rtl/teclado_cajero_if.sv
// Keypad/cajero signal bundle; master drives card, keys and cajero status, slave is the keypad controller.
interface teclado_cajero_if;
  logic        tarjeta_recibida;
  logic        tecla_valida;
  logic [3:0]  tecla;
  logic        pin_incorrecto;
  logic        bloqueo;
  logic [3:0]  digito;
  logic        digito_stb;
  logic        tipo_transaccion;
  logic [31:0] monto;
  logic        monto_stb;
  logic [2:0]  estado;

  modport master (
    output tarjeta_recibida, tecla_valida, tecla, pin_incorrecto, bloqueo,
    input  digito, digito_stb, tipo_transaccion, monto, monto_stb, estado
  );

  modport slave (
    input  tarjeta_recibida, tecla_valida, tecla, pin_incorrecto, bloqueo,
    output digito, digito_stb, tipo_transaccion, monto, monto_stb, estado
  );
endinterface

// File: rtl/teclado_cajero_acumulador.sv
// acumulador_decimal: acc <= acc*10 + digito on load, one cycle; clear wins over load.
// TECLADO_LIMITE_MONTO_EN: loads beyond MONTO_MAX_DIGITOS digits are dropped until clear.
module acumulador_decimal
  import teclado_cajero_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic [3:0]  digito,
  output logic [31:0] acc
);
  logic [31:0] acc_sig;

  // x10 as x8 + x2, truncated to 32 bits
  assign acc_sig = (acc << 3) + (acc << 1) + {28'd0, digito};

`ifdef TECLADO_LIMITE_MONTO_EN
  logic [3:0] n_dig;
  logic       lleno;

  assign lleno = (n_dig >= 4'(MONTO_MAX_DIGITOS));

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc   <= '0;
      n_dig <= '0;
    end else if (load && !lleno) begin
      acc   <= acc_sig;
      n_dig <= n_dig + 4'd1;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (rst || clear) acc <= '0;
    else if (load)    acc <= acc_sig;
  end
`endif
endmodule

// File: rtl/teclado_cajero_defs.vh
// Shared constants for the ATM keypad: state codes, special key codes and the amount digit limit.
`ifndef TECLADO_CAJERO_DEFS_VH
`define TECLADO_CAJERO_DEFS_VH

localparam logic [2:0] ST_IDLE      = 3'd0;
localparam logic [2:0] ST_PIN       = 3'd1;
localparam logic [2:0] ST_TIPO      = 3'd2;
localparam logic [2:0] ST_MONTO     = 3'd3;
localparam logic [2:0] ST_FIN       = 3'd4;
localparam logic [2:0] ST_BLOQUEADO = 3'd5;

localparam logic [3:0] TECLA_DEPOSITO = 4'h1;
localparam logic [3:0] TECLA_RETIRO   = 4'h2;
localparam logic [3:0] TECLA_ENTER    = 4'hA;
localparam logic [3:0] TECLA_BORRAR   = 4'hB;
localparam logic [3:0] TECLA_CANCELAR = 4'hC;

// 9 digits caps the amount at 999999999
localparam int unsigned MONTO_MAX_DIGITOS = 9;

`endif

// File: rtl/teclado_cajero.sv
// ATM keypad controller: PIN digits and amount forwarded as strobes one cycle after the key; no backpressure.
// Optional amount digit limit via TECLADO_LIMITE_MONTO_EN (see acumulador_decimal).
module teclado_cajero
  import teclado_cajero_pkg::*;
(
  input logic             clk,
  input logic             rst,
  teclado_cajero_if.slave bus
);
  estado_t     estado_q, estado_n;
  logic [1:0]  cnt_q;
  logic [31:0] acc;
  logic        tecla_ok, es_dig, activo, cancelar;
  logic        dig_ev, tipo_ev, monto_ev, acc_load, acc_clear;

  assign tecla_ok = bus.tecla_valida;
  assign es_dig   = es_digito(bus.tecla);
  assign activo   = bus.tarjeta_recibida && !bus.bloqueo;
  assign cancelar = tecla_ok && (bus.tecla == TECLA_CANCELAR) &&
                    (estado_q != E_FIN) && (estado_q != E_BLOQUEADO);
  assign bus.estado = estado_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q             <= E_IDLE;
      cnt_q                <= '0;
      bus.digito           <= '0;
      bus.digito_stb       <= 1'b0;
      bus.monto            <= '0;
      bus.monto_stb        <= 1'b0;
      bus.tipo_transaccion <= 1'b0;
    end else begin
      estado_q       <= estado_n;
      cnt_q          <= (estado_q != E_PIN) ? 2'd0 : cnt_q + {1'b0, dig_ev};
      bus.digito_stb <= dig_ev;
      bus.monto_stb  <= monto_ev;
      if (dig_ev)   bus.digito           <= bus.tecla;
      if (monto_ev) bus.monto            <= acc;
      if (tipo_ev)  bus.tipo_transaccion <= (bus.tecla == TECLA_RETIRO);
    end
  end

  always_comb begin
    estado_n = estado_q;
    if (!bus.tarjeta_recibida)  estado_n = E_IDLE;
    else if (bus.bloqueo)       estado_n = E_BLOQUEADO;
    else if (cancelar)          estado_n = E_FIN;
    else begin
      case (estado_q)
        E_IDLE:  estado_n = E_PIN;
        E_PIN:   if (dig_ev && cnt_q == 2'd3) estado_n = E_TIPO;
        E_TIPO: begin
          if (bus.pin_incorrecto) estado_n = E_PIN;
          else if (tipo_ev)       estado_n = E_MONTO;
        end
        E_MONTO: begin
          if (bus.pin_incorrecto) estado_n = E_PIN;
          else if (monto_ev)      estado_n = E_FIN;
        end
        default: estado_n = estado_q;
      endcase
    end
  end

  // Higher-priority events (card out, block, cancel, wrong PIN) suppress every key action
  always_comb begin
    dig_ev    = 1'b0;
    tipo_ev   = 1'b0;
    monto_ev  = 1'b0;
    acc_load  = 1'b0;
    acc_clear = (estado_q != E_MONTO);
    if (activo && !cancelar && tecla_ok) begin
      dig_ev = (estado_q == E_PIN) && es_dig;
      if (!bus.pin_incorrecto) begin
        tipo_ev  = (estado_q == E_TIPO) &&
                   ((bus.tecla == TECLA_DEPOSITO) || (bus.tecla == TECLA_RETIRO));
        monto_ev = (estado_q == E_MONTO) && (bus.tecla == TECLA_ENTER);
        acc_load = (estado_q == E_MONTO) && es_dig;
        if ((estado_q == E_MONTO) && (bus.tecla == TECLA_BORRAR)) acc_clear = 1'b1;
      end
    end
  end

  acumulador_decimal u_acc (
    .clk    (clk),
    .rst    (rst),
    .clear  (acc_clear),
    .load   (acc_load),
    .digito (bus.tecla),
    .acc    (acc)
  );
endmodule

// File: tb/tb_teclado_cajero.sv
// Bench for teclado_cajero: directed sessions then random traffic against a session-level reference model.
module tb_teclado_cajero;
  import teclado_cajero_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  teclado_cajero_if bus();
  teclado_cajero dut (.clk(clk), .rst(rst), .bus(bus));

  int n_total = 0;
  int n_bad   = 0;

  typedef enum {M_IDLE, M_PIN, M_TIPO, M_MONTO, M_FIN, M_BLOQ} fase_t;
  fase_t           fase;
  int              pin_n, ndig;
  longint unsigned importe;
  logic [3:0]      e_dig;
  logic [31:0]     e_monto;
  logic            e_dstb, e_mstb, e_tipo;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [2:0] cod(input fase_t f);
    case (f)
      M_IDLE:  return ST_IDLE;
      M_PIN:   return ST_PIN;
      M_TIPO:  return ST_TIPO;
      M_MONTO: return ST_MONTO;
      M_FIN:   return ST_FIN;
      default: return ST_BLOQUEADO;
    endcase
  endfunction

  task automatic modelo(input bit r, input bit card, input bit valid, input int t,
                        input bit pinc, input bit bloq);
    e_dstb = 1'b0;
    e_mstb = 1'b0;
    if (r) begin
      fase = M_IDLE; pin_n = 0; ndig = 0; importe = 0;
      e_dig = '0; e_monto = '0; e_tipo = 1'b0;
    end else if (!card) fase = M_IDLE;
    else if (bloq) fase = M_BLOQ;
    else if (valid && t == 12 && fase != M_FIN && fase != M_BLOQ) fase = M_FIN;
    else begin
      case (fase)
        M_IDLE: begin fase = M_PIN; pin_n = 0; end
        M_PIN: if (valid && t <= 9) begin
          e_dig = 4'(t); e_dstb = 1'b1; pin_n++;
          if (pin_n == 4) fase = M_TIPO;
        end
        M_TIPO: begin
          if (pinc) begin fase = M_PIN; pin_n = 0; end
          else if (valid && (t == 1 || t == 2)) begin
            e_tipo = (t == 2); fase = M_MONTO; importe = 0; ndig = 0;
          end
        end
        M_MONTO: begin
          if (pinc) begin fase = M_PIN; pin_n = 0; importe = 0; ndig = 0; end
          else if (valid && t <= 9) begin
`ifdef TECLADO_LIMITE_MONTO_EN
            if (ndig < 9) begin
              importe = (importe * 10 + longint'(t)) % 64'h1_0000_0000; ndig++;
            end
`else
            importe = (importe * 10 + longint'(t)) % 64'h1_0000_0000; ndig++;
`endif
          end else if (valid && t == 11) begin importe = 0; ndig = 0; end
          else if (valid && t == 10) begin
            e_monto = importe[31:0]; e_mstb = 1'b1; fase = M_FIN;
          end
        end
        default: ;
      endcase
    end
  endtask

  task automatic ciclo(input bit r, input bit card, input bit valid, input int t,
                       input bit pinc, input bit bloq);
    @(negedge clk);
    rst = r;
    bus.tarjeta_recibida = card;
    bus.tecla_valida     = valid;
    bus.tecla            = 4'(t);
    bus.pin_incorrecto   = pinc;
    bus.bloqueo          = bloq;
    @(posedge clk);
    modelo(r, card, valid, t, pinc, bloq);
    #1;
    chk("estado",     32'(bus.estado),     32'(cod(fase)));
    chk("digito_stb", 32'(bus.digito_stb), 32'(e_dstb));
    chk("monto_stb",  32'(bus.monto_stb),  32'(e_mstb));
    chk("digito",     32'(bus.digito),     32'(e_dig));
    chk("monto",      bus.monto,           e_monto);
    chk("tipo",       32'(bus.tipo_transaccion), 32'(e_tipo));
  endtask

  task automatic key(input int t);
    ciclo(1'b0, 1'b1, 1'b1, t, 1'b0, 1'b0);
  endtask

  task automatic sesion_nueva();
    ciclo(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    ciclo(1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  initial begin
    rst = 1'b1;
    bus.tarjeta_recibida = 1'b0; bus.tecla_valida = 1'b0; bus.tecla = '0;
    bus.pin_incorrecto = 1'b0; bus.bloqueo = 1'b0;
    fase = M_IDLE; pin_n = 0; ndig = 0; importe = 0;
    e_dig = '0; e_monto = '0; e_tipo = 1'b0; e_dstb = 1'b0; e_mstb = 1'b0;

    ciclo(1'b1, 1'b1, 1'b1, 5, 1'b0, 1'b0);
    ciclo(1'b1, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("rst_estado", 32'(bus.estado), 32'(ST_IDLE));
    chk("rst_monto", bus.monto, 32'd0);

    // PIN 1,2,3,4 then withdrawal of 500
    sesion_nueva();
    for (int i = 1; i <= 4; i++) begin
      key(i);
      chk("pin_stb", 32'(bus.digito_stb), 32'd1);
      chk("pin_dig", 32'(bus.digito), 32'(i));
    end
    chk("pin_tipo", 32'(bus.estado), 32'(ST_TIPO));
    key(2); key(5); key(0); key(0); key(10);
    chk("m500_stb", 32'(bus.monto_stb), 32'd1);
    chk("m500", bus.monto, 32'd500);
    chk("m500_tipo", 32'(bus.tipo_transaccion), 32'd1);
    chk("m500_fin", 32'(bus.estado), 32'(ST_FIN));
    key(3);
    chk("fin_nostb", 32'(bus.digito_stb), 32'd0);

    // BORRAR in MONTO
    sesion_nueva();
    for (int i = 0; i < 4; i++) key(9);
    key(1); key(7); key(11); key(3); key(10);
    chk("borrar_monto", bus.monto, 32'd3);
    chk("borrar_tipo", 32'(bus.tipo_transaccion), 32'd0);

    // wrong PIN in TIPO, PIN re-entered
    sesion_nueva();
    for (int i = 0; i < 4; i++) key(1);
    ciclo(1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
    chk("pinc_estado", 32'(bus.estado), 32'(ST_PIN));
    for (int i = 5; i <= 8; i++) begin
      key(i);
      chk("pinc_dig", 32'(bus.digito), 32'(i));
    end
    chk("pinc_tipo", 32'(bus.estado), 32'(ST_TIPO));

    // block during PIN
    sesion_nueva();
    key(4);
    ciclo(1'b0, 1'b1, 1'b1, 6, 1'b0, 1'b1);
    chk("bloq_estado", 32'(bus.estado), 32'(ST_BLOQUEADO));
    chk("bloq_nostb", 32'(bus.digito_stb), 32'd0);
    key(3); key(12); key(10);
    chk("bloq_keys", 32'(bus.estado), 32'(ST_BLOQUEADO));
    ciclo(1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
    chk("bloq_idle", 32'(bus.estado), 32'(ST_IDLE));

    // amount width boundary
    sesion_nueva();
    for (int i = 0; i < 4; i++) key(2);
    key(1);
`ifdef TECLADO_LIMITE_MONTO_EN
    for (int i = 0; i < 10; i++) key(9);
    key(10);
    chk("limite", bus.monto, 32'd999999999);
`else
    begin
      int ovf[10] = '{4, 2, 9, 4, 9, 6, 7, 2, 9, 6};
      foreach (ovf[i]) key(ovf[i]);
    end
    key(10);
    chk("wrap", bus.monto, 32'd0);
`endif
    chk("wrap_stb", 32'(bus.monto_stb), 32'd1);

    // reset mid-PIN discards partial entry
    sesion_nueva();
    key(7); key(8);
    ciclo(1'b1, 1'b1, 1'b1, 9, 1'b0, 1'b0);
    chk("rst_mid_stb", 32'(bus.digito_stb), 32'd0);
    chk("rst_mid_dig", 32'(bus.digito), 32'd0);

    for (int n = 0; n < 4000; n++) begin
      bit r, card, valid, pinc, bloq;
      int t;
      r     = ($urandom_range(0, 199) == 0);
      card  = ($urandom_range(0, 99) != 0);
      bloq  = ($urandom_range(0, 149) == 0);
      pinc  = ($urandom_range(0, 39) == 0);
      valid = ($urandom_range(0, 1) == 1);
      t     = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 15));
      ciclo(r, card, valid, t, pinc, bloq);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
